// File: rtl/and_event_qualifier.sv
// and_event_qualifier
// -------------------
// Synchronizes two raw asynchronous operands, ANDs them, and recognises an
// event once the AND has stayed high for STABLE consecutive cycles. Every
// qualified event bumps a saturating counter, and a snapshot of that counter
// is offered over a valid/ready handshake. A sticky flag records events that
// arrive while an earlier report is still waiting to be accepted.
//
// Parameters:
//   WIDTH  - event counter / snapshot width (>= 1)
//   STABLE - consecutive high cycles of the synchronized AND that qualify an
//            event (>= 1)
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   a, b        in   raw operands, asynchronous to clk
//   clr         in   synchronous clear of counter, report and drop flag
//   evt_valid   out  a report is pending
//   evt_ready   in   consumer accepts the pending report
//   evt_count   out  counter value captured at the reported event
//   evt_dropped out  sticky: an event was lost while a report was pending
module and_event_qualifier #(
  parameter int WIDTH  = 8,
  parameter int STABLE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_count,
  output logic             evt_dropped
);

  // Run counter only has to reach STABLE; keep it at least one bit wide.
  localparam int RUN_W = (STABLE < 2) ? 1 : $clog2(STABLE + 1);
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(STABLE);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMING = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic             a_meta_r, a_sync_r;
  logic             b_meta_r, b_sync_r;
  logic             w_s;
  logic [1:0]       state_r, state_nxt_s;
  logic [RUN_W-1:0] run_r, run_nxt_s, run_inc_s;
  logic             fire_s;
  logic [WIDTH-1:0] cnt_r, cnt_inc_s;
  logic             evt_valid_r;
  logic [WIDTH-1:0] evt_count_r;
  logic             evt_dropped_r;

  // Two-flop synchronizers on both raw operands; clr deliberately not applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta_r <= 1'b0;
      a_sync_r <= 1'b0;
      b_meta_r <= 1'b0;
      b_sync_r <= 1'b0;
    end else begin
      a_meta_r <= a;
      a_sync_r <= a_meta_r;
      b_meta_r <= b;
      b_sync_r <= b_meta_r;
    end
  end

  assign w_s       = a_sync_r & b_sync_r;
  assign run_inc_s = run_r + RUN_W'(1);
  // Saturate: once all ones, further events report the maximum value.
  assign cnt_inc_s = (&cnt_r) ? cnt_r : cnt_r + WIDTH'(1);

  // Qualification FSM: next state, run count and the one-cycle event strobe.
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = run_r;
    fire_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        run_nxt_s = {RUN_W{1'b0}};
        if (w_s) begin
          if (STABLE == 1) begin
            fire_s      = 1'b1;
            state_nxt_s = ST_ACTIVE;
          end else begin
            state_nxt_s = ST_ARMING;
            run_nxt_s   = RUN_W'(1);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMING: begin
        if (!w_s) begin
          state_nxt_s = ST_IDLE;
          run_nxt_s   = {RUN_W{1'b0}};
        end else if (run_inc_s == RUN_TGT) begin
          fire_s      = 1'b1;
          state_nxt_s = ST_ACTIVE;
          run_nxt_s   = {RUN_W{1'b0}};
        end else begin
          state_nxt_s = ST_ARMING;
          run_nxt_s   = run_inc_s;
        end
      end
      ST_ACTIVE: begin
        // Release is not debounced: one low cycle re-arms the detector.
        run_nxt_s = {RUN_W{1'b0}};
        if (!w_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        run_nxt_s   = {RUN_W{1'b0}};
      end
    endcase
  end

  // FSM state and run counter registers; clr does not disturb qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      run_r   <= {RUN_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      run_r   <= run_nxt_s;
    end
  end

  // Event counter and report handshake; clr outranks events and transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= {WIDTH{1'b0}};
      evt_valid_r   <= 1'b0;
      evt_count_r   <= {WIDTH{1'b0}};
      evt_dropped_r <= 1'b0;
    end else if (clr) begin
      cnt_r         <= {WIDTH{1'b0}};
      evt_valid_r   <= 1'b0;
      evt_count_r   <= {WIDTH{1'b0}};
      evt_dropped_r <= 1'b0;
    end else if (fire_s) begin
      cnt_r <= cnt_inc_s;
      // A report slot is free if empty or being accepted on this same edge.
      if (!evt_valid_r || evt_ready) begin
        evt_count_r <= cnt_inc_s;
        evt_valid_r <= 1'b1;
      end else begin
        evt_dropped_r <= 1'b1;
      end
    end else if (evt_valid_r && evt_ready) begin
      evt_valid_r <= 1'b0;
    end else begin
      evt_valid_r <= evt_valid_r;
    end
  end

  assign evt_valid   = evt_valid_r;
  assign evt_count   = evt_count_r;
  assign evt_dropped = evt_dropped_r;

endmodule
